trunc_level_governor: RTL
=========================

// Module: trunc_level_governor
// PURPOSE
//   Closed-loop driver of the 4-bit truncation select consumed by TruncationController.
//   Accumulates error-magnitude samples from the approximate datapath over a fixed window.
//   Steps sel up (more truncation) when the windowed error is low, and down when it is high.
//   Each sel change is committed through a req/ack handshake, so the datapath switches masks only when idle.
// PARAMETERS
//   ERR_W      16  width of one error-magnitude sample
//   WIN_LOG2   4   window length = 2**WIN_LOG2 accepted samples
//   SEL_RESET  0   sel value after reset (4-bit)
//   ACC_W      ERR_W+WIN_LOG2 (localparam) window accumulator / threshold width
// PORTS
//   wb_clk_i     in   1      single clock, all state on rising edge
//   wb_rst_i     in   1      reset, asynchronous, active-high
//   enable       in   1      governor active; low = hold sel, discard window
//   err_valid    in   1      err_mag valid this cycle
//   err_ready    out  1      sample accepted when err_valid & err_ready
//   err_mag      in   ERR_W  unsigned error magnitude
//   thr_hi       in   ACC_W  window sum > thr_hi -> step sel down
//   thr_lo       in   ACC_W  window sum < thr_lo -> step sel up
//   sel_min      in   4      lowest allowed sel
//   sel_max      in   4      highest allowed sel
//   sel          out  4      committed truncation select (to TruncationController.sel)
//   sel_pend     out  4      proposed sel, valid while sel_upd_req high
//   sel_upd_req  out  1      request to commit sel_pend
//   sel_upd_ack  in   1      datapath idle, commit accepted
//   win_sum      out  ACC_W  last completed window sum (debug)
// BEHAVIOUR
//   Reset values: sel=SEL_RESET, sel_pend=SEL_RESET, sel_upd_req=0, err_ready=0, win_sum=0; state IDLE, acc=0, cnt=0.
//   FSM states: IDLE, ACCUM, DECIDE, UPDATE.
//   IDLE: err_ready=0. Goes to ACCUM the cycle after enable=1.
//   ACCUM: err_ready=1.
//     - Each accepted sample: acc += err_mag, saturating at all-ones.
//     - Each accepted sample: cnt += 1.
//     - When the 2**WIN_LOG2-th sample is accepted: win_sum <= final acc (including that sample); go to DECIDE.
//   DECIDE (1 cycle): err_ready=0. Clears acc and cnt. Compares win_sum in this order:
//     - sel_min > sel_max: no change, back to ACCUM.
//     - sel outside [sel_min, sel_max]: sel_pend = nearest bound, go to UPDATE.
//     - win_sum > thr_hi and sel > sel_min: sel_pend = sel-1, go to UPDATE.
//     - win_sum < thr_lo and sel < sel_max: sel_pend = sel+1, go to UPDATE.
//     - otherwise: back to ACCUM.
//     - thr_hi checked before thr_lo, so overlapping thresholds favour less truncation.
//   UPDATE: sel_upd_req=1, err_ready=0, sel_pend held stable.
//     - On sel_upd_ack: sel <= sel_pend the same edge; req drops next cycle; go to ACCUM.
//     - Waits indefinitely for ack; sel_upd_ack outside UPDATE is ignored.
//   sel moves at most one step per window, except the clamp case, which jumps to the bound.
//   enable=0 in any state: next state IDLE, acc/cnt cleared, req dropped, sel held.
//     - In UPDATE, an ack in that same cycle still commits.
//   Async reset mid-window or mid-handshake: all state returns to reset values immediately.
//   Thresholds and bounds are sampled only in DECIDE and may change freely at other times.
// CONFIGURATION
//   TRUNC_GOV_STATS_EN defined:
//     - Adds output chg_count[15:0]: increments on every committed sel change, wraps at 16'hFFFF -> 0.
//     - Adds output sat_seen: sticky, set when acc saturates.
//     - Both reset to 0 on wb_rst_i.
//   TRUNC_GOV_STATS_EN undefined: neither port nor its logic exists; all other behaviour identical.
// STRUCTURE
//   Shared package trunc_pkg:
//     - SEL_W=4
//     - FSM state enum (IDLE/ACCUM/DECIDE/UPDATE)
//     - sel clamp helper function
//   One sub-module, trunc_win_accum:
//     - saturating accumulator + sample counter + window-done strobe
//     - ports clk/rst/clr/in_valid/in_data/acc/done
//   Top level holds the FSM, decision compare and handshake registers.
// TESTING
//   1. Reset with SEL_RESET=0, enable=1, 16 samples of err_mag=1, thr_lo=100, thr_hi=1000, bounds 0..15
//      -> win_sum=16, req=1 with sel_pend=1; ack -> sel=1.
//   2. sel=5, 16 samples of err_mag=200, thr_hi=1000 -> win_sum=3200, sel_pend=4;
//      hold ack low 10 cycles -> req stays 1, err_ready=0, sel stays 5.
//   3. Bound hold: sel=15, sel_max=15, low error -> no req, back to ACCUM;
//      set sel_min=8 while sel=3 -> next DECIDE gives sel_pend=8.
//   4. Saturation: ERR_W=16, 16 samples of 16'hFFFF -> win_sum=20'hFFFF0, no wrap;
//      with stats enabled, sat_seen stays 0 at exactly full scale.
//   5. enable dropped after 7 samples -> IDLE, acc cleared;
//      re-enable -> next window needs a full 16 samples.
//      Async reset during UPDATE -> req=0, sel=SEL_RESET at once.
//   6. TRUNC_GOV_STATS_EN: 3 committed changes -> chg_count=3;
//      preload-style run of 65536 changes -> chg_count wraps to 0.

Source files
------------

// File: rtl/trunc_pkg.sv
// Shared types for the truncation-level governor: select width, FSM states, clamp helper.
package trunc_pkg;

    localparam int unsigned SEL_W = 4;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2,
        UPDATE = 2'd3
    } gov_state_e;

    // Pull v into [lo, hi]; caller guarantees lo <= hi.
    function automatic sel_t sel_clamp(input sel_t v, input sel_t lo, input sel_t hi);
        sel_t r;
        r = v;
        if (v < lo) r = lo;
        if (v > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/trunc_win_accum.sv
// Windowed saturating accumulator with sample counter and window-done strobe.
// Optional TRUNC_GOV_STATS_EN adds a saturation-event output.
module trunc_win_accum #(
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned CNT_W  = 4,
    localparam int unsigned ACC_W  = DATA_W + CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [ACC_W-1:0]  acc,
    output logic              done
`ifdef TRUNC_GOV_STATS_EN
    ,
    output logic              sat
`endif
);

    localparam int unsigned SUM_W = ACC_W + 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sum_c;
    logic [ACC_W-1:0] sat_sum_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // acc/done describe the running total including the sample accepted this cycle.
    always_comb begin
        sum_c     = {1'b0, acc_q} + SUM_W'(in_data);
        sat_sum_c = sum_c[ACC_W] ? '1 : sum_c[ACC_W-1:0];
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            acc_d = sat_sum_c;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign acc  = in_valid ? sat_sum_c : acc_q;
    assign done = in_valid && !clr && (cnt_q == '1);

`ifdef TRUNC_GOV_STATS_EN
    assign sat = in_valid && !clr && sum_c[ACC_W];
`endif

endmodule

// File: rtl/trunc_level_governor.sv
// Closed-loop governor for the 4-bit truncation select, committed via req/ack handshake.
// Define TRUNC_GOV_STATS_EN to add chg_count and sat_seen statistics outputs.
module trunc_level_governor
    import trunc_pkg::*;
#(
    parameter  int unsigned ERR_W     = 16,
    parameter  int unsigned WIN_LOG2  = 4,
    parameter  sel_t        SEL_RESET = 4'd0,
    localparam int unsigned ACC_W     = ERR_W + WIN_LOG2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             enable,
    input  logic             err_valid,
    output logic             err_ready,
    input  logic [ERR_W-1:0] err_mag,
    input  logic [ACC_W-1:0] thr_hi,
    input  logic [ACC_W-1:0] thr_lo,
    input  logic [SEL_W-1:0] sel_min,
    input  logic [SEL_W-1:0] sel_max,
    output logic [SEL_W-1:0] sel,
    output logic [SEL_W-1:0] sel_pend,
    output logic             sel_upd_req,
    input  logic             sel_upd_ack,
    output logic [ACC_W-1:0] win_sum
`ifdef TRUNC_GOV_STATS_EN
    ,
    output logic [15:0]      chg_count,
    output logic             sat_seen
`endif
);

    gov_state_e       state_q, state_d;
    sel_t             sel_q, sel_d;
    sel_t             sel_pend_q, sel_pend_d;
    logic             req_q, req_d;
    logic             err_ready_q, err_ready_d;
    logic [ACC_W-1:0] win_sum_q, win_sum_d;

    logic             accept_c;
    logic             clr_c;
    logic             commit_c;
    logic [ACC_W-1:0] acc_c;
    logic             win_done_c;
    logic             dec_upd_c;
    sel_t             dec_sel_c;

    assign accept_c = err_valid && err_ready_q;
    assign clr_c    = !enable || (state_q == DECIDE);
    assign commit_c = (state_q == UPDATE) && sel_upd_ack;

`ifdef TRUNC_GOV_STATS_EN
    logic        acc_sat_c;
    logic [15:0] chg_count_q, chg_count_d;
    logic        sat_seen_q, sat_seen_d;
`endif

    trunc_win_accum #(
        .DATA_W (ERR_W),
        .CNT_W  (WIN_LOG2)
    ) u_win_accum (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .clr      (clr_c),
        .in_valid (accept_c),
        .in_data  (err_mag),
        .acc      (acc_c),
        .done     (win_done_c)
`ifdef TRUNC_GOV_STATS_EN
        ,
        .sat      (acc_sat_c)
`endif
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            sel_q       <= SEL_RESET;
            sel_pend_q  <= SEL_RESET;
            req_q       <= 1'b0;
            err_ready_q <= 1'b0;
            win_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_pend_q  <= sel_pend_d;
            req_q       <= req_d;
            err_ready_q <= err_ready_d;
            win_sum_q   <= win_sum_d;
        end
    end

    // Decision on the completed window; a clamp back into bounds outranks threshold steps.
    always_comb begin
        dec_upd_c = 1'b0;
        dec_sel_c = sel_q;
        if (sel_min > sel_max) begin
            dec_upd_c = 1'b0;
        end else if ((sel_q < sel_min) || (sel_q > sel_max)) begin
            dec_upd_c = 1'b1;
            dec_sel_c = sel_clamp(sel_q, sel_min, sel_max);
        end else if ((win_sum_q > thr_hi) && (sel_q > sel_min)) begin
            dec_upd_c = 1'b1;
            dec_sel_c = sel_q - SEL_W'(1);
        end else if ((win_sum_q < thr_lo) && (sel_q < sel_max)) begin
            dec_upd_c = 1'b1;
            dec_sel_c = sel_q + SEL_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = ACCUM;
                ACCUM:   if (win_done_c) state_d = DECIDE;
                DECIDE:  state_d = dec_upd_c ? UPDATE : ACCUM;
                UPDATE:  if (sel_upd_ack) state_d = ACCUM;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sel_d       = sel_q;
        sel_pend_d  = sel_pend_q;
        win_sum_d   = win_sum_q;
        req_d       = (state_d == UPDATE);
        err_ready_d = (state_d == ACCUM);
        if (commit_c) begin
            sel_d = sel_pend_q;
        end
        if ((state_q == DECIDE) && enable && dec_upd_c) begin
            sel_pend_d = dec_sel_c;
        end
        if ((state_q == ACCUM) && enable && win_done_c) begin
            win_sum_d = acc_c;
        end
    end

    assign err_ready   = err_ready_q;
    assign sel         = sel_q;
    assign sel_pend    = sel_pend_q;
    assign sel_upd_req = req_q;
    assign win_sum     = win_sum_q;

`ifdef TRUNC_GOV_STATS_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            chg_count_q <= '0;
            sat_seen_q  <= 1'b0;
        end else begin
            chg_count_q <= chg_count_d;
            sat_seen_q  <= sat_seen_d;
        end
    end

    always_comb begin
        chg_count_d = commit_c ? chg_count_q + 16'd1 : chg_count_q;
        sat_seen_d  = sat_seen_q || acc_sat_c;
    end

    assign chg_count = chg_count_q;
    assign sat_seen  = sat_seen_q;
`endif

endmodule
